// File: rtl/full_add_pkg.sv
// full_add_pkg -- shared constants for the full_add block.
//   DEF_WIDTH : default operand width of full_add
//   CNT_W     : width of the carry-out event counter
//   CNT_MAX   : saturation value of that counter
package full_add_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int CNT_W     = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

endpackage : full_add_pkg

// File: rtl/half_add.sv
// half_add -- single-bit half adder, the building block of each full_add slice.
// Ports:
//   a, b : input bits
//   s    : sum bit   (a ^ b)
//   c    : carry bit (a & b)
module half_add (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule : half_add

// File: rtl/full_add.sv
// full_add -- WIDTH-bit ripple-carry adder with combinational and registered
// results, plus an optional saturating count of cycles that carried out.
// Ports:
//   clk       : rising-edge clock for the registered outputs
//   rst_n     : asynchronous active-low reset (clears sum_q, cout_q, carry_cnt)
//   a, b      : unsigned addends, WIDTH bits
//   cin       : carry-in
//   sum, cout : combinational result, {cout,sum} = a + b + cin
//   sum_q     : sum registered one cycle later
//   cout_q    : cout registered one cycle later
//   carry_cnt : saturating (255) count of clocked cycles with cout=1
// Configuration macro: FULL_ADD_CARRY_CNT_EN. When undefined, carry_cnt is
// tied to zero and no counter flops are built.
module full_add
  import full_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic [CNT_W-1:0] carry_cnt
);

  // carry_s[i] is the carry into bit i; carry_s[WIDTH] is the final carry-out
  logic [WIDTH:0] carry_s;

  assign carry_s[0] = cin;

  // Each slice: first half adder combines the operand bits, second folds in
  // the incoming carry; the two half-adder carries can never both be 1, so OR
  // is an exact carry-out.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic p_s;
    logic g_s;
    logic c2_s;

    half_add u_ha_op (
      .a (a[i]),
      .b (b[i]),
      .s (p_s),
      .c (g_s)
    );

    half_add u_ha_cin (
      .a (p_s),
      .b (carry_s[i]),
      .s (sum[i]),
      .c (c2_s)
    );

    assign carry_s[i+1] = g_s | c2_s;
  end

  assign cout = carry_s[WIDTH];

`ifdef FULL_ADD_CARRY_CNT_EN
  logic [CNT_W-1:0] cnt_r;

  // Result registers and saturating carry-out counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= {WIDTH{1'b0}};
      cout_q <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
      if (cout && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign carry_cnt = cnt_r;
`else
  // Result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= {WIDTH{1'b0}};
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
    end
  end

  assign carry_cnt = {CNT_W{1'b0}};
`endif

endmodule : full_add

// File: tb/tb_full_add.sv
// tb_full_add -- self-checking bench for full_add at WIDTH=1 and WIDTH=8.
// Expected registered results are queued when a vector is driven and popped
// one clock edge later. carry_cnt is checked against a bench-side model that
// follows FULL_ADD_CARRY_CNT_EN.
module tb_full_add;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic       sum1, cout1, sum_q1, cout_q1;
  logic [7:0] cnt1;

  logic [7:0] a8 = 8'd0, b8 = 8'd0;
  logic       cin8 = 1'b0;
  logic [7:0] sum8, sum_q8;
  logic       cout8, cout_q8;
  logic [7:0] cnt8;

  int         n_vec = 0;
  int         n_bad = 0;

  logic [1:0] q1[$];
  logic [8:0] q8[$];
  int         cnt_exp1 = 0;
  int         cnt_exp8 = 0;

  always #5 clk = ~clk;

  full_add #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1),
    .sum(sum1), .cout(cout1), .sum_q(sum_q1), .cout_q(cout_q1), .carry_cnt(cnt1)
  );

  full_add #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8),
    .sum(sum8), .cout(cout8), .sum_q(sum_q8), .cout_q(cout_q8), .carry_cnt(cnt8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cnt_next(input int cur, input logic c);
`ifdef FULL_ADD_CARRY_CNT_EN
    if (c && cur < 255) return cur + 1;
    return cur;
`else
    return 0;
`endif
  endfunction

  // Drive one vector to both DUTs, check the combinational result at once,
  // then check the registered result and counter one edge later.
  task automatic apply(input logic av1, input logic bv1, input logic cv1,
                       input logic [7:0] av8, input logic [7:0] bv8, input logic cv8);
    logic [1:0] e1, r1;
    logic [8:0] e8, r8;
    a1 = av1; b1 = bv1; cin1 = cv1;
    a8 = av8; b8 = bv8; cin8 = cv8;
    e1 = {1'b0, av1} + {1'b0, bv1} + {1'b0, cv1};
    e8 = {1'b0, av8} + {1'b0, bv8} + {8'd0, cv8};
    #1;
    chk("comb1", {30'd0, cout1, sum1}, {30'd0, e1});
    chk("comb8", {23'd0, cout8, sum8}, {23'd0, e8});
    q1.push_back(e1);
    q8.push_back(e8);
    @(posedge clk);
    if (rst_n) begin
      cnt_exp1 = cnt_next(cnt_exp1, e1[1]);
      cnt_exp8 = cnt_next(cnt_exp8, e8[8]);
    end
    #1;
    r1 = q1.pop_front();
    r8 = q8.pop_front();
    chk("reg1", {30'd0, cout_q1, sum_q1}, {30'd0, r1});
    chk("reg8", {23'd0, cout_q8, sum_q8}, {23'd0, r8});
    chk("cnt1", {24'd0, cnt1}, cnt_exp1);
    chk("cnt8", {24'd0, cnt8}, cnt_exp8);
  endtask

  initial begin
    logic [2:0] v;
    // Reset held: registers cleared, combinational path still live
    #2;
    a1 = 1'b1; a8 = 8'h5A; b8 = 8'h03;
    #1;
    chk("rst_sum_q1", {31'd0, sum_q1}, 32'd0);
    chk("rst_cout_q1", {31'd0, cout_q1}, 32'd0);
    chk("rst_sum_q8", {24'd0, sum_q8}, 32'd0);
    chk("rst_cnt1", {24'd0, cnt1}, 32'd0);
    chk("rst_cnt8", {24'd0, cnt8}, 32'd0);
    chk("rst_comb1", {30'd0, cout1, sum1}, 32'd1);
    chk("rst_comb8", {23'd0, cout8, sum8}, 32'h05D);
    #4; // t=7, past the edge at t=5 which occurred under reset
    chk("rst_edge_sum_q8", {24'd0, sum_q8}, 32'd0);
    rst_n = 1'b1;

    // Exhaustive WIDTH=1, one vector per clock period
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      apply(v[2], v[1], v[0], 8'(i * 37), 8'(255 - i * 11), v[0]);
    end

    // 1+1+1 before an edge: comb at once, registered one edge later
    apply(1'b1, 1'b1, 1'b1, 8'hFF, 8'h01, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1);
    apply(1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1);
    apply(1'b1, 1'b0, 1'b0, 8'h80, 8'h80, 1'b0);

    // Async reset pulse between edges with sum_q1=1
    #2;
    rst_n = 1'b0;
    #1;
    cnt_exp1 = 0;
    cnt_exp8 = 0;
    chk("pulse_sum_q1", {31'd0, sum_q1}, 32'd0);
    chk("pulse_cout_q1", {31'd0, cout_q1}, 32'd0);
    chk("pulse_sum_q8", {24'd0, sum_q8}, 32'd0);
    chk("pulse_cout_q8", {31'd0, cout_q8}, 32'd0);
    chk("pulse_cnt1", {24'd0, cnt1}, 32'd0);
    chk("pulse_cnt8", {24'd0, cnt8}, 32'd0);
    chk("pulse_comb1", {30'd0, cout1, sum1}, 32'd1);
    #1;
    rst_n = 1'b1;

    // Random vectors
    for (int i = 0; i < 20; i++) begin
      apply(1'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Carry held high for 300 edges: counter saturates (or stays 0)
    for (int i = 0; i < 300; i++) begin
      apply(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
    end
`ifdef FULL_ADD_CARRY_CNT_EN
    chk("sat_cnt1", {24'd0, cnt1}, 32'd255);
    chk("sat_cnt8", {24'd0, cnt8}, 32'd255);
`else
    chk("off_cnt1", {24'd0, cnt1}, 32'd0);
    chk("off_cnt8", {24'd0, cnt8}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_full_add

// File: doc/full_add.md
FULL_ADD -- requirements
Module: full_add

Interface
REQ-001 Parameter: WIDTH, 1, operand width in bits (legal range 1..32).
REQ-002 Port: clk  input  1  rising-edge clock for all registered outputs.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low; the only reset.
REQ-004 Port: a  input  WIDTH  addend A, unsigned.
REQ-005 Port: b  input  WIDTH  addend B, unsigned.
REQ-006 Port: cin  input  1  carry-in.
REQ-007 Port: sum  output  WIDTH  combinational sum bits.
REQ-008 Port: cout  output  1  combinational carry-out.
REQ-009 Port: sum_q  output  WIDTH  registered copy of sum.
REQ-010 Port: cout_q  output  1  registered copy of cout.
REQ-011 Port: carry_cnt  output  8  saturating count of clocked cycles with cout=1 (see Configuration).

Function
REQ-012 {cout,sum} SHALL equal a + b + cin, computed at WIDTH+1 bits, zero extension, no truncation of the carry.
REQ-013 sum and cout SHALL be purely combinational; zero-cycle latency; no dependence on clk or rst_n.
REQ-014 WIDTH=1: sum = a XOR b XOR cin; cout = (a AND b) OR (cin AND (a XOR b)).
REQ-015 WIDTH>1: ripple-carry chain; bit i carry-in = bit i-1 carry-out; bit 0 carry-in = cin; cout = MSB carry-out.
REQ-016 sum_q/cout_q SHALL load sum/cout on every rising clk edge while rst_n=1; latency exactly 1 cycle.
REQ-017 No handshake; every edge samples; no enable or stall.
REQ-018 Wrap-around: all-ones + all-ones + 1 -> sum all-ones, cout 1; all-ones + 0 + 1 -> sum 0, cout 1.
REQ-019 X/Z on inputs: no requirement; all-known inputs SHALL produce fully known outputs.

Reset
REQ-020 rst_n low SHALL clear sum_q, cout_q and carry_cnt to 0 immediately, without waiting for clk.
REQ-021 While rst_n is low, registered outputs SHALL hold 0; combinational sum/cout SHALL keep tracking the inputs.
REQ-022 Deassertion: the first rising edge with rst_n=1 loads the registers normally.
REQ-023 Reset asserted mid-operation SHALL discard register state; there is no recovery of prior values.

Configuration
REQ-024 Macro FULL_ADD_CARRY_CNT_EN defined: carry_cnt SHALL increment by 1 on each rising edge where cout=1 and rst_n=1, and SHALL saturate at 255 (never wrap).
REQ-025 Macro absent: carry_cnt SHALL be a constant 0 and no counter flops SHALL exist; all other behaviour unchanged.

Structure
REQ-026 Package full_add_pkg SHALL hold: default WIDTH constant (1), CNT_W=8, CNT_MAX=255.
REQ-027 Sub-module half_add (ports a, b, s, c) SHALL be used; each bit = two half_add instances + OR for carry.
REQ-028 Use generate over WIDTH for the bit slices; one always_ff block for the registers and the counter.

Verification
REQ-029 WIDTH=1, exhaustive (a,b,cin)=000..111, one vector per 10 time units -> (sum,cout) = 00,10,10,01,10,01,01,11.
REQ-030 WIDTH=1, apply a=1 b=1 cin=1 before an edge -> sum/cout at once; sum_q=1 cout_q=1 exactly one edge later.
REQ-031 Pulse rst_n low between edges with sum_q=1 -> sum_q, cout_q, carry_cnt read 0 before the next edge.
REQ-032 WIDTH=8: a=8'hFF b=8'h01 cin=0 -> sum=8'h00 cout=1; a=8'hFF b=8'hFF cin=1 -> sum=8'hFF cout=1.
REQ-033 FULL_ADD_CARRY_CNT_EN defined, cout held 1 for 300 edges -> carry_cnt=255 and stays 255; undefined -> carry_cnt=0 throughout.
